// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags. The FIFO takes the slave
// modport and the producer/consumer side takes the master modport.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, valid, empty, full, almost_empty, almost_full,
               data_count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, valid, empty, full, almost_empty, almost_full,
               data_count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO that buffers audio samples, with an optional first-word-fall-through
// read mode, an occupancy count, almost-full/empty thresholds and overflow/underflow pulses.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int DEPTH         = 1024,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_flags_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("sync_fifo_flags: DEPTH must equal 2**ADDR_WIDTH");
    end

    // Storage carries no reset so it can map onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   store_count;
    logic [DATA_WIDTH-1:0] dout_p1;
    logic                  vld_p1;
    logic                  overflow_p1;
    logic                  underflow_p1;
    logic                  full_c;
    logic                  empty_c;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  load;

    // In FWFT mode the output register counts as a held word, so storage
    // holds count minus that word; load refills it when it is free or popped.
    always_comb begin
        full_c      = (count == CNT_FULL);
        empty_c     = (count == '0);
        store_count = count;
        wr_acc      = bus.wr_en & ~full_c;
        rd_acc      = 1'b0;
        load        = 1'b0;
        if (FWFT != 0) begin
            store_count = count - {{ADDR_WIDTH{1'b0}}, vld_p1};
            empty_c     = ~vld_p1;
            rd_acc      = bus.rd_en & vld_p1;
            load        = (~vld_p1 | rd_acc) & (store_count != '0);
        end else begin
            rd_acc = bus.rd_en & ~empty_c;
            load   = rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Stage p1: pointers, occupancy, output word and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout_p1      <= '0;
            vld_p1       <= 1'b0;
            overflow_p1  <= 1'b0;
            underflow_p1 <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                dout_p1 <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (FWFT != 0) begin
                vld_p1 <= load | (vld_p1 & ~rd_acc);
            end else begin
                vld_p1 <= rd_acc;
            end
            overflow_p1  <= bus.wr_en & full_c;
            underflow_p1 <= bus.rd_en & empty_c;
        end
    end

    assign bus.dout         = dout_p1;
    assign bus.valid        = vld_p1;
    assign bus.empty        = empty_c;
    assign bus.full         = full_c;
    assign bus.almost_empty = (count <= CNT_AE);
    assign bus.almost_full  = (count >= CNT_AF);
    assign bus.data_count   = count;
    assign bus.overflow     = overflow_p1;
    assign bus.underflow    = underflow_p1;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances share one stimulus stream
// and are compared against queue-based reference models, a vector table and hand sequences.
module tb_sync_fifo_flags;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FWFT(0),
                      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE))
        u_std (.clk(clk), .rst(rst), .bus(bus0));

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FWFT(1),
                      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE))
        u_fwft (.clk(clk), .rst(rst), .bus(bus1));

    int checks   = 0;
    int failures = 0;

    // Reference state: a queue of every held word per mode.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] m_dout0 = '0, m_dout1 = '0;
    logic          m_vld0 = 1'b0, m_vis1 = 1'b0;
    logic          m_ovf0 = 1'b0, m_unf0 = 1'b0, m_ovf1 = 1'b0, m_unf1 = 1'b0;

    typedef struct {
        logic          rst, wr, rd;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          valid, empty, full, ae, af;
        logic [AW:0]   cnt;
        logic          ovf, unf;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [26:0] pack0();
        return {bus0.dout, bus0.valid, bus0.empty, bus0.full, bus0.almost_empty,
                bus0.almost_full, bus0.data_count, bus0.overflow, bus0.underflow};
    endfunction

    function automatic logic [26:0] pack1();
        return {bus1.dout, bus1.valid, bus1.empty, bus1.full, bus1.almost_empty,
                bus1.almost_full, bus1.data_count, bus1.overflow, bus1.underflow};
    endfunction

    function automatic vec_t mk(input logic r, input logic w, input logic rd,
                                input logic [DW-1:0] d, input logic [DW-1:0] o,
                                input logic v, input logic e, input logic f,
                                input logic ae, input logic af, input logic [AW:0] c,
                                input logic ov, input logic un);
        vec_t x;
        x.rst = r; x.wr = w; x.rd = rd; x.din = d; x.dout = o; x.valid = v;
        x.empty = e; x.full = f; x.ae = ae; x.af = af; x.cnt = c; x.ovf = ov; x.unf = un;
        return x;
    endfunction

    // Advance both reference models by one clock edge using the pre-edge inputs.
    task automatic model_edge(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        logic f0, e0, f1, e1;
        if (r) begin
            q0.delete(); q1.delete();
            m_dout0 = '0; m_dout1 = '0; m_vld0 = 1'b0; m_vis1 = 1'b0;
            m_ovf0 = 1'b0; m_unf0 = 1'b0; m_ovf1 = 1'b0; m_unf1 = 1'b0;
            return;
        end
        f0 = (q0.size() == DEPTH); e0 = (q0.size() == 0);
        m_ovf0 = w & f0; m_unf0 = rd & e0;
        m_vld0 = rd & !e0;
        if (m_vld0) m_dout0 = q0.pop_front();
        if (w && !f0) q0.push_back(d);

        f1 = (q1.size() == DEPTH); e1 = !m_vis1;
        m_ovf1 = w & f1; m_unf1 = rd & e1;
        if (rd && m_vis1) void'(q1.pop_front());
        // The head shows once it was already stored before this edge.
        m_vis1 = (q1.size() > 0);
        if (m_vis1) m_dout1 = q1[0];
        if (w && !f1) q1.push_back(d);
    endtask

    task automatic check_model();
        logic [26:0] e0, e1;
        e0 = {m_dout0, m_vld0, q0.size() == 0, q0.size() == DEPTH, q0.size() <= AE,
              q0.size() >= AF, (AW+1)'(q0.size()), m_ovf0, m_unf0};
        e1 = {m_dout1, m_vis1, !m_vis1, q1.size() == DEPTH, q1.size() <= AE,
              q1.size() >= AF, (AW+1)'(q1.size()), m_ovf1, m_unf1};
        chk("model_std", 32'(pack0()), 32'(e0));
        chk("model_fwft", 32'(pack1()), 32'(e1));
    endtask

    task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        rst = r;
        bus0.wr_en = w; bus0.rd_en = rd; bus0.din = d;
        bus1.wr_en = w; bus1.rd_en = rd; bus1.din = d;
        @(posedge clk);
        model_edge(r, w, rd, d);
        #1;
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Vector table for the standard-mode instance.
        vt[0] = mk(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++)
            vt[i] = mk(1'b0, 1'b1, 1'b0, 16'(i), 16'h0, 1'b0, 1'b0, i == 8, i <= 1, i >= 6,
                       4'(i), 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++)
            vt[10+k] = mk(1'b0, 1'b0, 1'b1, 16'h0, 16'(k), 1'b1, k == 8, 1'b0, (8-k) <= 1,
                          (8-k) >= 6, 4'(8-k), 1'b0, 1'b0);
        vt[19] = mk(1'b0, 1'b0, 1'b1, 16'h0, 16'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            cycle(vt[i].rst, vt[i].wr, vt[i].rd, vt[i].din);
            chk($sformatf("vec%0d", i), 32'(pack0()),
                32'({vt[i].dout, vt[i].valid, vt[i].empty, vt[i].full, vt[i].ae, vt[i].af,
                     vt[i].cnt, vt[i].ovf, vt[i].unf}));
        end

        // FWFT: a lone write appears two edges later without any read request.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h00A5);
        chk("fwft_edge_n_valid", 32'(bus1.valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        chk("fwft_valid", 32'(bus1.valid), 32'd1);
        chk("fwft_dout", 32'(bus1.dout), 32'h00A5);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        chk("fwft_pop_valid", 32'(bus1.valid), 32'd0);
        chk("fwft_pop_empty", 32'(bus1.empty), 32'd1);

        // Four words held, then simultaneous write and read for 20 cycles.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 16'(16'h0100 + i));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 16'(16'h0104 + i));
            chk("simul_count", 32'(bus0.data_count), 32'd4);
            chk("simul_order", 32'(bus0.dout), 32'(16'h0100 + i));
        end

        // Full with write and read together: read wins, write rejected.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 16'(16'h0200 + i));
        cycle(1'b0, 1'b1, 1'b1, 16'hBEEF);
        chk("full_rw_count", 32'(bus0.data_count), 32'd7);
        chk("full_rw_ovf", 32'(bus0.overflow), 32'd1);
        chk("full_rw_dout", 32'(bus0.dout), 32'h0200);

        // Reset while holding five words with a write pending.
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0);
        cycle(1'b1, 1'b1, 1'b0, 16'hDEAD);
        chk("rst_count", 32'(bus1.data_count), 32'd0);
        chk("rst_dout", 32'(bus1.dout), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst_no_store", 32'(bus0.data_count), 32'd0);

        // Randomized traffic with phases biased toward filling and draining.
        for (int n = 0; n < 3000; n++) begin
            int pw, pr;
            case ((n / 200) % 3)
                0: begin pw = 75; pr = 30; end
                1: begin pw = 30; pr = 75; end
                default: begin pw = 50; pr = 50; end
            endcase
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) < pw,
                  $urandom_range(0, 99) < pr, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised successor to the IIS dual-clock FIFO, used to buffer audio samples between the IIS datapath and the APB/DMA side when both run on one clock.
- Adds an optional first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses.
- No Gray-code synchronisers. Storage is not reset, so synthesis can infer RAM.

Parameters:
- DATA_WIDTH, 16, data word width.
- ADDR_WIDTH, 10, address bits; depth is 2**ADDR_WIDTH.
- DEPTH, 1024, must equal 2**ADDR_WIDTH (elaboration-time check).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-4, almost_full asserts when data_count >= this value.
- AEMPTY_THRESH, 4, almost_empty asserts when data_count <= this value.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read request (standard mode) / pop (FWFT mode)
- dout  out  DATA_WIDTH  read data
- valid  out  1  standard mode: 1-cycle pulse when dout is updated; FWFT mode: dout holds the head word
- empty  out  1  nothing readable
- full  out  1  no write accepted
- almost_empty  out  1  data_count <= AEMPTY_THRESH
- almost_full  out  1  data_count >= AFULL_THRESH
- data_count  out  ADDR_WIDTH+1  words held, including any FWFT output word; range 0..DEPTH
- overflow  out  1  1-cycle pulse, write attempted while full
- underflow  out  1  1-cycle pulse, read attempted while empty

Behaviour:
- Reset (rst=1 at a rising edge):
  - Next cycle: pointers 0, data_count 0, dout 0, valid 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0.
  - Mid-operation reset discards all contents; wr_en/rd_en are ignored in the reset cycle.
- Accepted write: wr_en & !full stores din at wr_ptr; wr_ptr increments by 1 with natural wrap at DEPTH.
- Accepted read, standard mode: rd_en & !empty.
  - dout <= mem[rd_ptr] at the edge; valid=1 for exactly that following cycle; rd_ptr increments.
  - Otherwise dout holds its value and valid=0. Read latency is 1 cycle.
- FWFT mode:
  - An internal output register is filled from storage whenever it is empty or popped, and storage is non-empty.
  - valid=1 while the output register is full; empty = !valid.
  - rd_en & valid pops the head. If a next word exists, dout shows it in the following cycle with valid held 1.
  - Write into a completely empty FIFO: the word is written at edge N and becomes valid with dout=din after edge N+1, i.e. 2 cycles after wr_en is sampled.
- full and empty decisions use the registered state at the current edge. There is no same-cycle bypass.
- Simultaneous accepted write and read: data_count is unchanged.
  - When full, a write is rejected even if a read happens in the same cycle.
  - When empty, a read is rejected even if a write happens in the same cycle.
- data_count: +1 on an accepted write only, -1 on an accepted read only. Width ADDR_WIDTH+1, so DEPTH is representable.
- Flag derivation: full = (data_count==DEPTH). empty (standard mode) = (data_count==0). almost flags are combinational compares of the registered data_count.
- overflow is registered: it pulses in the cycle after wr_en & full. underflow likewise pulses after rd_en & empty. Neither pulse changes state.
- Rejected operations leave memory, pointers and dout unchanged.

Test Plan:
- Setup for all scenarios: DATA_WIDTH=16, ADDR_WIDTH=3, DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=1.
- Reset, then write 0x0001..0x0008 on consecutive cycles -> data_count steps 1..8; almost_empty drops when count reaches 2; almost_full rises at count 6; full=1 at count 8. A 9th write of 0xFFFF -> overflow pulses 1 cycle, data_count stays 8, and later reads return no 0xFFFF.
- FWFT=0, FIFO full, 8 consecutive rd_en -> dout=0x0001..0x0008, each one cycle after its rd_en with valid pulsed each time; empty=1 after the last read. An extra rd_en -> underflow pulses, dout holds 0x0008, valid=0.
- FWFT=1, empty FIFO, single write of 0x00A5 at edge N -> valid=1 and dout=0x00A5 after edge N+1 without any rd_en; rd_en pops it -> valid=0, empty=1 the next cycle.
- FIFO holding 4 words, wr_en and rd_en asserted together for 20 cycles with an incrementing pattern -> data_count constant at 4, pointers wrap past 7 and data order is preserved. Also, full with wr_en+rd_en together -> read accepted, write rejected, overflow=1.
- Assert rst while holding 5 words with wr_en=1 -> next cycle data_count=0, empty=1, valid=0, dout=0, and the din presented in the reset cycle is not stored.
